simd_alu_rr_scheduler: RTL and testbench

- Shares one SIMD lockstep ALU (LANES x BIT_WIDTH, bit-serial, start/done handshake) among NUM_REQ requesters, such as shader warps.
- Round-robin arbitration picks one requester. The block latches its opcode and operand vectors, sequences the ALU, and returns a tagged result through a valid/ready response port.
- Sits between the issue stage and the ALU instance. The ALU's start, op_code, a and b inputs are driven only by this block.

---
 rtl/simd_alu_rr_scheduler.sv | 134 +++++++++++++
 tb/tb_simd_alu_rr_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_rr_scheduler.sv
// Round-robin front end for one shared bit-serial SIMD ALU.
// Picks one requester, latches its opcode and operand vectors, starts the ALU,
// waits for completion, and returns the result tagged with the requester id.
module simd_alu_rr_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int LANES     = 4,
    parameter int BIT_WIDTH = 32
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_REQ-1:0]                          req_valid,
    output logic [NUM_REQ-1:0]                          req_ready,
    input  logic [NUM_REQ-1:0][1:0]                     req_op,
    input  logic [NUM_REQ-1:0][LANES-1:0][BIT_WIDTH-1:0] req_a,
    input  logic [NUM_REQ-1:0][LANES-1:0][BIT_WIDTH-1:0] req_b,
    output logic                                        alu_start,
    output logic [1:0]                                  alu_op,
    output logic [LANES-1:0][BIT_WIDTH-1:0]             alu_a,
    output logic [LANES-1:0][BIT_WIDTH-1:0]             alu_b,
    input  logic                                        alu_done,
    input  logic [LANES-1:0][BIT_WIDTH-1:0]             alu_result,
    input  logic [LANES-1:0]                            alu_div_by_zero,
    output logic                                        resp_valid,
    input  logic                                        resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]                  resp_id,
    output logic [LANES-1:0][BIT_WIDTH-1:0]             resp_result,
    output logic [LANES-1:0]                            resp_div_by_zero,
    output logic                                        busy
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t                          state_q, state_d;
    logic [IDW-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [1:0]                      alu_op_q, alu_op_d;
    logic [LANES-1:0][BIT_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [LANES-1:0][BIT_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [IDW-1:0]                  resp_id_q, resp_id_d;
    logic [LANES-1:0][BIT_WIDTH-1:0] resp_result_q, resp_result_d;
    logic [LANES-1:0]                resp_dbz_q, resp_dbz_d;

    logic                            win_vld;
    logic [IDW-1:0]                  win_id;

    // Round-robin search: first valid requester strictly after the last winner.
    always_comb begin
        logic [IDW-1:0] idx;
        idx     = '0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_vld && req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    // Sequencer: grant in IDLE, one-cycle start, wait for done, hold response.
    // req_ready is masked by reset so no handshake is offered while aborting.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_dbz_d    = resp_dbz_q;
        req_ready     = '0;
        case (state_q)
            IDLE: begin
                if (win_vld && !reset) begin
                    req_ready[win_id] = 1'b1;
                    alu_op_d          = req_op[win_id];
                    alu_a_d           = req_a[win_id];
                    alu_b_d           = req_b[win_id];
                    resp_id_d         = win_id;
                    rr_ptr_d          = win_id;
                    state_d           = ISSUE;
                end
            end
            ISSUE: state_d = BUSY;
            BUSY: begin
                if (alu_done) begin
                    resp_result_d = alu_result;
                    resp_dbz_d    = alu_div_by_zero;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= IDW'(NUM_REQ - 1);
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_dbz_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_dbz_q    <= resp_dbz_d;
        end
    end

    assign alu_start        = (state_q == ISSUE);
    assign resp_valid       = (state_q == RESP);
    assign busy             = (state_q != IDLE);
    assign alu_op           = alu_op_q;
    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign resp_id          = resp_id_q;
    assign resp_result      = resp_result_q;
    assign resp_div_by_zero = resp_dbz_q;

endmodule

// File: tb/tb_simd_alu_rr_scheduler.sv
// Bench for simd_alu_rr_scheduler: bench-side ALU with random latency,
// directed scenarios followed by randomized traffic, all outputs checked
// every cycle against a transaction-level reference model.
module tb_simd_alu_rr_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int LANES     = 4;
    localparam int BIT_WIDTH = 32;
    localparam int IDW       = $clog2(NUM_REQ);

    typedef logic [LANES-1:0][BIT_WIDTH-1:0] vec_t;

    logic                          clk   = 1'b0;
    logic                          reset = 1'b0;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][1:0]       req_op;
    logic [NUM_REQ-1:0][LANES-1:0][BIT_WIDTH-1:0] req_a, req_b;
    logic                          alu_start;
    logic [1:0]                    alu_op;
    vec_t                          alu_a, alu_b, alu_result;
    logic                          alu_done;
    logic [LANES-1:0]              alu_div_by_zero;
    logic                          resp_valid, resp_ready;
    logic [IDW-1:0]                resp_id;
    vec_t                          resp_result;
    logic [LANES-1:0]              resp_div_by_zero;
    logic                          busy;

    always #5 clk = ~clk;

    simd_alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .LANES(LANES), .BIT_WIDTH(BIT_WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_div_by_zero(alu_div_by_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_div_by_zero(resp_div_by_zero), .busy(busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Lane arithmetic of the bench ALU; divide by zero yields all ones.
    function automatic vec_t calc_res(input logic [1:0] op, input vec_t a, input vec_t b);
        vec_t r;
        for (int l = 0; l < LANES; l++) begin
            case (op)
                2'd0:    r[l] = a[l] + b[l];
                2'd1:    r[l] = a[l] - b[l];
                2'd2:    r[l] = a[l] * b[l];
                default: r[l] = (b[l] == 0) ? '1 : a[l] / b[l];
            endcase
        end
        return r;
    endfunction

    function automatic logic [LANES-1:0] calc_dz(input logic [1:0] op, input vec_t b);
        logic [LANES-1:0] dz;
        for (int l = 0; l < LANES; l++) dz[l] = (op == 2'd3) && (b[l] == 0);
        return dz;
    endfunction

    // Reference model: one job at a time, winner = nearest valid id after last grant.
    int               m_last     = NUM_REQ - 1;
    bit               m_free     = 1'b1;
    bit               m_start    = 1'b0;
    bit               m_inflight = 1'b0;
    bit               m_pend     = 1'b0;
    logic [IDW-1:0]   m_id;
    logic [1:0]       m_op;
    vec_t             m_a, m_b, m_res;
    logic [LANES-1:0] m_dz;
    int               gnt_cnt [NUM_REQ];
    int               grant_log [$];
    int               n_resp = 0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_rdy;
        int w;
        exp_rdy = '0;
        w       = -1;
        if (reset) begin
            m_last = NUM_REQ - 1; m_free = 1'b1; m_start = 1'b0;
            m_inflight = 1'b0; m_pend = 1'b0;
        end else begin
            if (m_free)
                for (int k = 1; k <= NUM_REQ; k++)
                    if (w < 0 && req_valid[(m_last + k) % NUM_REQ]) w = (m_last + k) % NUM_REQ;
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, !m_free);
            chk("alu_start", alu_start, m_start);
            if (!m_free) chk("alu_opnd", {alu_op, alu_a, alu_b}, {m_op, m_a, m_b});
            chk("resp_valid", resp_valid, m_pend);
            if (m_pend) chk("resp", {resp_id, resp_div_by_zero, resp_result}, {m_id, m_dz, m_res});
            m_start = 1'b0;
            if (m_pend && resp_ready) begin
                m_pend = 1'b0; m_free = 1'b1; n_resp++;
            end else if (m_inflight && alu_done) begin
                m_inflight = 1'b0; m_pend = 1'b1;
            end
            if (w >= 0) begin
                m_free = 1'b0; m_start = 1'b1; m_inflight = 1'b1; m_last = w;
                m_id = IDW'(w); m_op = req_op[w]; m_a = req_a[w]; m_b = req_b[w];
                m_res = calc_res(m_op, m_a, m_b);
                m_dz  = calc_dz(m_op, m_b);
                gnt_cnt[w]++;
                grant_log.push_back(w);
            end
        end
    end

    // Stimulus state
    bit         rand_req = 1'b0, rand_rr = 1'b0, spur_en = 1'b0;
    int         seen_cnt [NUM_REQ];
    int         alu_cnt = 0;
    logic [1:0] c_op;
    vec_t       c_a, c_b;

    task automatic new_req(input int i);
        req_valid[i] = 1'b1;
        req_op[i]    = 2'($urandom_range(0, 3));
        for (int l = 0; l < LANES; l++) begin
            req_a[i][l] = $urandom;
            req_b[i][l] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input vec_t a, input vec_t b);
        req_valid[i] = 1'b1; req_op[i] = op; req_a[i] = a; req_b[i] = b;
    endtask

    // One clock: bench ALU, requester bookkeeping, optional random backpressure.
    task automatic step();
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        if (reset) alu_cnt = 0;
        else if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_done        = 1'b1;
                alu_result      = calc_res(c_op, c_a, c_b);
                alu_div_by_zero = calc_dz(c_op, c_b);
            end
        end else if (alu_start) begin
            c_op = alu_op; c_a = alu_a; c_b = alu_b;
            alu_cnt = $urandom_range(1, 6);
        end else if (spur_en && $urandom_range(0, 5) == 0) begin
            alu_done = 1'b1;
            for (int l = 0; l < LANES; l++) alu_result[l] = $urandom;
            alu_div_by_zero = LANES'($urandom);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_cnt[i] != seen_cnt[i]) begin
                seen_cnt[i]  = gnt_cnt[i];
                req_valid[i] = 1'b0;
            end else if (rand_req && req_valid[i] && $urandom_range(0, 31) == 0) begin
                req_valid[i] = 1'b0;
            end
            if (rand_req && !req_valid[i] && $urandom_range(0, 3) == 0) new_req(i);
        end
        if (rand_rr) resp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {req_ready, alu_start, alu_op, resp_valid, resp_id, resp_div_by_zero, busy}, '0);
        chk({tag, "_alu"}, {alu_a, alu_b}, '0);
        chk({tag, "_res"}, resp_result, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs("rst");
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        int t = 0;
        while (!resp_valid && t < 100) begin step(); t++; end
        chk({tag, "_resp_arrives"}, resp_valid, 1'b1);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((busy || req_valid != 0) && t < 400) begin step(); t++; end
        chk({tag, "_drained"}, {busy, req_valid}, '0);
    endtask

    int   g0, r0, t;
    int   exp_ord [5] = '{0, 1, 2, 3, 0};
    logic [133:0] snap;

    initial begin
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        alu_done = 1'b0; alu_result = '0; alu_div_by_zero = '0; resp_ready = 1'b1;
        #1;
        do_reset();

        // Single ADD request from requester 2
        set_req(2, 2'd0, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10});
        g0 = grant_log.size();
        wait_resp("t1");
        chk("t1_id", resp_id, 2);
        chk("t1_res", resp_result, {32'd44, 32'd33, 32'd22, 32'd11});
        step(); step();
        chk("t1_grants", grant_log.size() - g0, 1);
        drain("t1");

        // All four requesters valid continuously: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) new_req(i);
        g0 = grant_log.size();
        r0 = n_resp;
        t = 0;
        while (n_resp < r0 + 5 && t < 300) begin
            step();
            for (int i = 0; i < NUM_REQ; i++) if (!req_valid[i]) new_req(i);
            t++;
        end
        req_valid = '0;
        for (int k = 0; k < 5; k++)
            chk($sformatf("t2_order%0d", k),
                (g0 + k < grant_log.size()) ? grant_log[g0 + k] : -1, exp_ord[k]);
        drain("t2");

        // DIV with a zero divisor in lane 1
        set_req(1, 2'd3, {32'd8, 32'd9, 32'd7, 32'd100}, {32'd2, 32'd3, 32'd0, 32'd10});
        wait_resp("t3");
        chk("t3_dz", resp_div_by_zero, 4'b0010);
        chk("t3_id", resp_id, 1);
        chk("t3_res", resp_result, {32'd4, 32'd3, 32'hFFFF_FFFF, 32'd10});
        drain("t3");

        // Backpressure for 20 cycles with pending requests and spurious done pulses
        resp_ready = 1'b0;
        spur_en    = 1'b1;
        set_req(0, 2'd2, {32'd5, 32'd6, 32'd7, 32'd8}, {32'd3, 32'd3, 32'd3, 32'd3});
        wait_resp("t4");
        for (int i = 1; i < NUM_REQ; i++) new_req(i);
        snap = {resp_id, resp_div_by_zero, resp_result};
        for (int k = 0; k < 20; k++) step();
        chk("t4_hold", {resp_id, resp_div_by_zero, resp_result}, snap);
        chk("t4_no_grant", req_ready, '0);
        resp_ready = 1'b1;
        step();
        chk("t4_next_grant", req_ready, 4'b0010);
        drain("t4");
        spur_en = 1'b0;

        // Reset while the ALU is busy
        for (int i = 0; i < NUM_REQ; i++) new_req(i);
        t = 0;
        while (alu_cnt == 0 && t < 50) begin step(); t++; end
        step();
        chk("t5_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_reset_outputs("t5_rst");
        new_req(0);
        step();
        reset = 1'b0;
        g0 = grant_log.size();
        step();
        chk("t5_first", (g0 < grant_log.size()) ? grant_log[g0] : -1, 0);
        step();
        req_valid = '0;
        drain("t5");

        // Randomized traffic
        rand_req = 1'b1; rand_rr = 1'b1; spur_en = 1'b1;
        r0 = n_resp;
        for (int k = 0; k < 3000; k++) step();
        rand_req = 1'b0; rand_rr = 1'b0; spur_en = 1'b0;
        resp_ready = 1'b1;
        req_valid = '0;
        drain("rand");
        chk("rand_progress", (n_resp - r0) > 50, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
